// File: rtl/pipe_ctrl.sv
// Pipeline controller for the in-order core: produces hold/flush/redirect
// controls for pc_reg, if_id and id_ex, plus stall/flush performance counters.
module pipe_ctrl #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jump_en_i,
    input  logic [31:0]      jump_addr_i,
    input  logic             mc_start_i,
    input  logic             mc_done_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             ex_is_load_i,
    output logic             pc_jump_en_o,
    output logic [31:0]      pc_jump_addr_o,
    output logic             pc_hold_o,
    output logic             if_id_hold_o,
    output logic             if_id_flush_o,
    output logic             id_ex_hold_o,
    output logic             id_ex_flush_o,
    output logic             mc_abort_o,
    output logic             mc_timeout_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [15:0]      flush_cnt_o
);

    localparam int MCW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;

    typedef enum logic {
        RUN,
        MC_WAIT
    } state_t;

    state_t           r_state;
    logic [MCW-1:0]   r_mcCnt;
    logic [CNT_W-1:0] r_stallCnt;
    logic [15:0]      r_flushCnt;
    logic             r_timeout;

    logic w_hz;
    logic w_mcLast;
    logic w_jump;
    logic w_pcHold;
    logic w_ifHold;
    logic w_ifFlush;
    logic w_idHold;
    logic w_idFlush;
    logic w_abort;
    logic w_busy;

    assign w_hz = ex_is_load_i && (ex_rd_addr_i != 5'd0) &&
                  ((id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                   (id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i)));

    assign w_mcLast = (r_mcCnt == MCW'(MC_TIMEOUT - 1));

    // Controls are combinational so they act at the very next edge; reset masks them all.
    always_comb begin
        w_jump    = 1'b0;
        w_pcHold  = 1'b0;
        w_ifHold  = 1'b0;
        w_ifFlush = 1'b0;
        w_idHold  = 1'b0;
        w_idFlush = 1'b0;
        w_abort   = 1'b0;
        w_busy    = 1'b0;
        if (!rst) begin
            case (r_state)
                RUN: begin
                    if (jump_en_i) begin
                        w_jump    = 1'b1;
                        w_ifFlush = 1'b1;
                        w_idFlush = 1'b1;
                    end else if (mc_start_i) begin
                        w_pcHold = 1'b1;
                        w_ifHold = 1'b1;
                        w_idHold = 1'b1;
                    end else if (w_hz) begin
                        w_pcHold  = 1'b1;
                        w_ifHold  = 1'b1;
                        w_idFlush = 1'b1;
                    end
                end
                MC_WAIT: begin
                    w_busy = 1'b1;
                    if (!mc_done_i) begin
                        if (w_mcLast) begin
                            w_abort = 1'b1;
                        end else begin
                            w_pcHold = 1'b1;
                            w_ifHold = 1'b1;
                            w_idHold = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Jumps and hazards are ignored while waiting because EX still owns the multi-cycle op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RUN;
            r_mcCnt    <= '0;
            r_stallCnt <= '0;
            r_flushCnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_pcHold)
                r_stallCnt <= r_stallCnt + CNT_W'(1);
            if (w_jump && (r_flushCnt != 16'hFFFF))
                r_flushCnt <= r_flushCnt + 16'd1;
            if (w_abort)
                r_timeout <= 1'b1;
            case (r_state)
                RUN: begin
                    if (!jump_en_i && mc_start_i) begin
                        r_state <= MC_WAIT;
                        r_mcCnt <= '0;
                    end
                end
                MC_WAIT: begin
                    if (mc_done_i || w_mcLast)
                        r_state <= RUN;
                    else
                        r_mcCnt <= r_mcCnt + MCW'(1);
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign pc_jump_en_o   = w_jump;
    assign pc_jump_addr_o = w_jump ? jump_addr_i : 32'd0;
    assign pc_hold_o      = w_pcHold;
    assign if_id_hold_o   = w_ifHold;
    assign if_id_flush_o  = w_ifFlush;
    assign id_ex_hold_o   = w_idHold;
    assign id_ex_flush_o  = w_idFlush;
    assign mc_abort_o     = w_abort;
    assign mc_timeout_o   = r_timeout;
    assign busy_o         = w_busy;
    assign stall_cnt_o    = r_stallCnt;
    assign flush_cnt_o    = r_flushCnt;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the in-order RISC-V core. It sequences the pc_reg, if_id and id_ex stages by generating hold, flush and jump-redirect controls. Sources of these controls are taken jumps/branches resolved in EX, load-use hazards, and multi-cycle EX operations such as mul/div, which have a timeout watchdog. It also keeps stall and flush performance counters.

Parameters:
MC_TIMEOUT, 64, maximum MC_WAIT cycles before a multi-cycle op is aborted (>=2)
CNT_W, 32, width of stall_cnt_o

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
jump_en_i  in  1  EX resolved taken jump/branch this cycle
jump_addr_i  in  32  EX jump target
mc_start_i  in  1  EX issues a multi-cycle op (1-cycle pulse)
mc_done_i  in  1  multi-cycle unit result valid
id_rs1_addr_i  in  5  decode rs1 index
id_rs2_addr_i  in  5  decode rs2 index
id_rs1_used_i  in  1  decode reads rs1
id_rs2_used_i  in  1  decode reads rs2
ex_rd_addr_i  in  5  EX destination register
ex_is_load_i  in  1  EX instruction is a load
pc_jump_en_o  out  1  pc_reg loads pc_jump_addr_o at next edge
pc_jump_addr_o  out  32  redirect target
pc_hold_o  out  1  pc_reg keeps its value
if_id_hold_o  out  1  if_id keeps its contents
if_id_flush_o  out  1  if_id loads NOP (0x00000013) at next edge
id_ex_hold_o  out  1  id_ex keeps its contents
id_ex_flush_o  out  1  id_ex loads NOP/reg_wen=0 at next edge
mc_abort_o  out  1  1-cycle pulse: multi-cycle op timed out
mc_timeout_o  out  1  sticky timeout flag, cleared only by rst
busy_o  out  1  state is MC_WAIT
stall_cnt_o  out  CNT_W  cycles with pc_hold_o=1, wraps
flush_cnt_o  out  16  taken redirects, saturates at 0xFFFF

Behaviour:
- Reset (async, rst=1): state=RUN; mc_cnt=0; stall_cnt_o=0; flush_cnt_o=0; mc_timeout_o=0. While rst=1, every control output is forced to 0: pc_jump_en_o, holds, flushes, mc_abort_o and busy_o. pc_jump_addr_o is 0.
- All hold/flush/jump outputs are combinational from the current state and inputs. They take effect at the next clk edge in the target stages.
- pc_jump_addr_o = jump_addr_i whenever pc_jump_en_o=1, else 0.
- Load-use hazard hz is 1 when all of these hold:
  - ex_is_load_i=1
  - ex_rd_addr_i != 0
  - (id_rs1_used_i and id_rs1_addr_i == ex_rd_addr_i) or (id_rs2_used_i and id_rs2_addr_i == ex_rd_addr_i)
- State RUN, checked in priority order:
  1. jump_en_i=1: pc_jump_en_o=1, if_id_flush_o=1, id_ex_flush_o=1, no holds. flush_cnt_o increments (saturating). mc_start_i and hz are ignored this cycle.
  2. mc_start_i=1: pc_hold_o=if_id_hold_o=id_ex_hold_o=1. Next state is MC_WAIT with mc_cnt=0. mc_done_i is ignored this cycle.
  3. hz=1: pc_hold_o=1, if_id_hold_o=1, id_ex_flush_o=1, inserting one bubble. Stay in RUN.
  4. Otherwise: all controls are 0.
- State MC_WAIT (busy_o=1):
  - mc_done_i=1: all holds are 0 this cycle so the pipeline advances. Next state is RUN.
  - No done and mc_cnt == MC_TIMEOUT-1: holds are 0, mc_abort_o=1 and mc_timeout_o is set. Next state is RUN.
  - Otherwise: pc_hold_o=if_id_hold_o=id_ex_hold_o=1 and mc_cnt increments.
  - jump_en_i, mc_start_i and hz are ignored in MC_WAIT, because EX holds the multi-cycle instruction.
- Stall length: with done in the k-th MC_WAIT cycle, holds are asserted for exactly k cycles (the start cycle plus k-1 wait cycles). A timeout gives MC_TIMEOUT hold cycles, then the abort cycle.
- stall_cnt_o increments on every clk edge where pc_hold_o=1 and wraps modulo 2^CNT_W.
- Flush and hold are never both asserted on the same stage in the same cycle.

Test Plan:
- RUN, jump_en_i=1, jump_addr_i=0x00000080 -> same cycle pc_jump_en_o=1, pc_jump_addr_o=0x80, if_id_flush_o=id_ex_flush_o=1, no holds; flush_cnt_o 0->1 after the edge.
- Load-use: ex_is_load_i=1, ex_rd_addr_i=5, id_rs2_addr_i=5, id_rs2_used_i=1 -> pc_hold_o=if_id_hold_o=id_ex_flush_o=1 for one cycle; stall_cnt_o +1. Same stimulus with ex_rd_addr_i=0 -> no hold.
- mc_start_i pulse, mc_done_i in the 5th MC_WAIT cycle -> holds high for exactly 5 cycles; busy_o high 5 cycles (the 4 wait cycles plus the done cycle); holds 0 in the done cycle; stall_cnt_o +5; back in RUN.
- mc_start_i with no mc_done_i, MC_TIMEOUT=64 -> 64 hold cycles, then mc_abort_o=1 for exactly 1 cycle; mc_timeout_o stays 1 afterwards; holds drop to 0.
- jump_en_i=1, mc_start_i=1 and hz=1 together in RUN -> jump only; state stays RUN, no hold. Also: rst asserted mid-MC_WAIT (cycle 3) -> all outputs 0 immediately (asynchronous); after release, state is RUN and counters are 0.
